// File: rtl/sram_word_sequencer.sv
// sram_word_sequencer: Avalon-MM slave that runs single-word write/read
// cycles on an external 16-bit asynchronous SRAM. The write word comes from
// the upstream PIO (in_data) and is captured when a WRITE command is accepted.
// Optional feature macro: SRAM_SEQ_AUTOINC_EN (ADDR post-increments on each
// completed operation, wrapping at 20 bits).
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no cycle in flight; all SRAM controls inactive
// W_SETUP  | address/data/CE driven, WE still high
// W_STROBE | WE low; down-counter times WE_CYCLES cycles
// W_HOLD   | WE released, address/data held one more cycle
// R_ACCESS | CE/OE low; down-counter times RD_CYCLES, data sampled at end
module sram_word_sequencer #(
  parameter int WE_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] in_data,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_ACCESS = 3'd4
  } state_t;

  localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [19:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        done_q;
  logic        err_q;

  logic        busy;
  logic        bus_wr;
  logic        addr_wr;
  logic        cmd_wr;
  logic        cmd_one_hot;
  logic        accept_wr;
  logic        accept_rd;
  logic        cnt_tc;
  logic        op_done;
  logic        unused_bits;

  assign busy        = (state != IDLE);
  assign bus_wr      = chipselect & ~write_n;
  assign addr_wr     = bus_wr & (address == 2'd0);
  assign cmd_wr      = bus_wr & (address == 2'd1);
  assign cmd_one_hot = writedata[0] ^ writedata[1];
  assign accept_wr   = cmd_wr & ~busy & writedata[0] & ~writedata[1];
  assign accept_rd   = cmd_wr & ~busy & writedata[1] & ~writedata[0];
  assign cnt_tc      = (cnt == 4'd0);
  assign op_done     = (state == W_HOLD) | ((state == R_ACCESS) & cnt_tc);

  // readdata ignores read_n and the upper writedata bits are never stored
  assign unused_bits = ^{writedata[31:20], read_n};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic and SRAM control decode
  always_comb begin
    next_state = state;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_dq_oe = 1'b0;
    sram_dq_o  = 16'h0000;
    case (state)
      IDLE: begin
        if (accept_wr)      next_state = W_SETUP;
        else if (accept_rd) next_state = R_ACCESS;
      end
      W_SETUP: begin
        sram_ce_n  = 1'b0;
        sram_ub_n  = 1'b0;
        sram_lb_n  = 1'b0;
        sram_dq_oe = 1'b1;
        sram_dq_o  = wdata_q;
        next_state = W_STROBE;
      end
      W_STROBE: begin
        sram_ce_n  = 1'b0;
        sram_ub_n  = 1'b0;
        sram_lb_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
        sram_dq_o  = wdata_q;
        if (cnt_tc) next_state = W_HOLD;
      end
      W_HOLD: begin
        sram_ce_n  = 1'b0;
        sram_ub_n  = 1'b0;
        sram_lb_n  = 1'b0;
        sram_dq_oe = 1'b1;
        sram_dq_o  = wdata_q;
        next_state = IDLE;
      end
      R_ACCESS: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        if (cnt_tc) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Phase timer: preloaded for a read while idle, reloaded for the strobe in W_SETUP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt <= 4'd0;
    else if (state == IDLE)      cnt <= RD_LOAD;
    else if (state == W_SETUP)   cnt <= WE_LOAD;
    else if (!cnt_tc)            cnt <= cnt - 4'd1;
  end

  // Address register: bus writes when idle, optional post-increment on completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= 20'h00000;
    end else if (addr_wr && !busy) begin
      addr_q <= writedata[19:0];
`ifdef SRAM_SEQ_AUTOINC_EN
    end else if (op_done) begin
      addr_q <= addr_q + 20'd1;
`endif
    end
  end

  // Write word capture and read data sampling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      if (accept_wr)                        wdata_q <= in_data;
      if ((state == R_ACCESS) && cnt_tc)    rdata_q <= sram_dq_i;
    end
  end

  // Status flags; clear first so a same-write error or acceptance wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (busy) begin
      if (cmd_wr || addr_wr) err_q  <= 1'b1;
      if (op_done)           done_q <= 1'b1;
    end else if (cmd_wr) begin
      if (writedata[2]) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (cmd_one_hot)                     done_q <= 1'b0;
      if (writedata[0] && writedata[1])    err_q  <= 1'b1;
    end
  end

  assign sram_addr = addr_q;

  // Register read mux, zero wait states
  always_comb begin
    readdata = 32'h0000_0000;
    if (chipselect) begin
      case (address)
        2'd0:    readdata = {12'h000, addr_q};
        2'd1:    readdata = {29'h0, err_q, done_q, busy};
        2'd2:    readdata = {16'h0000, rdata_q};
        default: readdata = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_word_sequencer.sv
// Directed bench for sram_word_sequencer with default WE_CYCLES/RD_CYCLES.
module tb_sram_word_sequencer;

`ifdef SRAM_SEQ_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [15:0] in_data = 16'h0;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // SRAM model: 0xBEEF lives at 0x00123, everything else reads 0x5A5A
  assign sram_dq_i = (sram_addr == 20'h00123) ? 16'hBEEF : 16'h5A5A;

  sram_word_sequencer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .in_data(in_data), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  // Returns 1 ns after the sampling edge (T0)
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; address = a; writedata = d; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; address = a; read_n = 1'b0;
    #1 d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    bit idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      read_reg(2'd1, s);
      if (!s[0]) idle = 1'b1;
      else begin @(posedge clk); #1; end
    end
    vectors++;
    if (!idle) begin miscompares++; $display("FAIL wait_idle timeout busy=1 required busy=0"); end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    vectors++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 6'b111110) begin
      miscompares++; $display("FAIL reset_ctrl got %b required 111110",
        {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), d);
      vectors++;
      if (d !== 32'h0) begin miscompares++; $display("FAIL reset_reg%0d got %h required 0", a, d); end
    end
    vectors++;
    if ({sram_addr, sram_dq_o} !== 36'h0) begin
      miscompares++; $display("FAIL reset_bus got addr=%h dq=%h required 0", sram_addr, sram_dq_o);
    end
    bus_write(2'd3, 32'hFFFF_FFFF);
    read_reg(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reserved_reg got %h required 0", d); end
  endtask

  task automatic test_write();
    logic [31:0] s;
    bus_write(2'd0, 32'h0000_0123);
    in_data = 16'hBEEF;
    bus_write(2'd1, 32'h1);
    in_data = 16'h1234;
    // i = cycles after T0: 0 setup, 1-2 strobe, 3 hold, 4 idle
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      vectors++;
      if (sram_we_n !== ((i == 1 || i == 2) ? 1'b0 : 1'b1)) begin
        miscompares++; $display("FAIL wr_we_n c%0d got %b required %b", i, sram_we_n, !(i == 1 || i == 2));
      end
      if (i < 4) begin
        vectors++;
        if ({sram_dq_oe, sram_ce_n, sram_oe_n, sram_dq_o, sram_addr} !== {3'b101, 16'hBEEF, 20'h00123}) begin
          miscompares++; $display("FAIL wr_bus c%0d got oe=%b ce_n=%b oe_n=%b dq=%h addr=%h required 1 0 1 beef 00123",
            i, sram_dq_oe, sram_ce_n, sram_oe_n, sram_dq_o, sram_addr);
        end
      end
      read_reg(2'd1, s);
      vectors++;
      if (s !== ((i < 4) ? 32'h1 : 32'h2)) begin
        miscompares++; $display("FAIL wr_status c%0d got %h required %h", i, s, (i < 4) ? 32'h1 : 32'h2);
      end
    end
    vectors++;
    if ({sram_dq_oe, sram_dq_o, sram_ce_n} !== {1'b0, 16'h0, 1'b1}) begin
      miscompares++; $display("FAIL wr_idle got oe=%b dq=%h ce_n=%b required 0 0000 1", sram_dq_oe, sram_dq_o, sram_ce_n);
    end
  endtask

  task automatic test_read();
    logic [31:0] s;
    bus_write(2'd0, 32'h0000_0123);
    bus_write(2'd1, 32'h2);
    for (int i = 0; i <= 2; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      vectors++;
      if ({sram_oe_n, sram_ce_n, sram_we_n, sram_dq_oe} !== ((i < 2) ? 4'b0010 : 4'b1110)) begin
        miscompares++; $display("FAIL rd_ctrl c%0d got %b required %b", i,
          {sram_oe_n, sram_ce_n, sram_we_n, sram_dq_oe}, (i < 2) ? 4'b0010 : 4'b1110);
      end
      read_reg(2'd1, s);
      vectors++;
      if (s !== ((i < 2) ? 32'h1 : 32'h2)) begin
        miscompares++; $display("FAIL rd_status c%0d got %h required %h", i, s, (i < 2) ? 32'h1 : 32'h2);
      end
    end
    read_reg(2'd2, s);
    vectors++;
    if (s !== 32'h0000_BEEF) begin miscompares++; $display("FAIL rd_rdata got %h required 0000beef", s); end
  endtask

  task automatic test_errors();
    logic [31:0] s;
    bus_write(2'd0, 32'h0000_0123);
    in_data = 16'hC0DE;
    bus_write(2'd1, 32'h1);
    bus_write(2'd1, 32'h2);
    bus_write(2'd0, 32'h0000_0005);
    wait_idle();
    read_reg(2'd1, s);
    vectors++;
    if (s !== 32'h6) begin miscompares++; $display("FAIL busy_err_status got %h required 6", s); end
    read_reg(2'd0, s);
    vectors++;
    if (s !== (AUTOINC ? 32'h124 : 32'h123)) begin
      miscompares++; $display("FAIL busy_addr got %h required %h", s, AUTOINC ? 32'h124 : 32'h123);
    end
    bus_write(2'd1, 32'h4);
    read_reg(2'd1, s);
    vectors++;
    if (s !== 32'h0) begin miscompares++; $display("FAIL clr_status got %h required 0", s); end
    bus_write(2'd1, 32'h3);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
        miscompares++; $display("FAIL both_ctrl c%0d got %b required 1110", i,
          {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
      end
      @(posedge clk); #1;
    end
    read_reg(2'd1, s);
    vectors++;
    if (s !== 32'h4) begin miscompares++; $display("FAIL both_status got %h required 4", s); end
    bus_write(2'd1, 32'h6);
    read_reg(2'd1, s);
    vectors++;
    if (s !== 32'h1) begin miscompares++; $display("FAIL clr_read_status got %h required 1", s); end
    wait_idle();
  endtask

  task automatic test_wrap();
    logic [31:0] s;
    bus_write(2'd0, 32'h000F_FFFF);
    in_data = 16'h0F0F;
    bus_write(2'd1, 32'h1);
    wait_idle();
    read_reg(2'd0, s);
    vectors++;
    if (s !== (AUTOINC ? 32'h0 : 32'hF_FFFF)) begin
      miscompares++; $display("FAIL wrap_addr got %h required %h", s, AUTOINC ? 32'h0 : 32'hF_FFFF);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    bus_write(2'd0, 32'h0000_0077);
    in_data = 16'h5555;
    bus_write(2'd1, 32'h1);
    @(posedge clk); #1;
    vectors++;
    if (sram_we_n !== 1'b0) begin miscompares++; $display("FAIL mid_pre_we_n got %b required 0", sram_we_n); end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({sram_we_n, sram_ce_n, sram_dq_oe, sram_dq_o, sram_addr} !== {3'b110, 16'h0, 20'h0}) begin
      miscompares++; $display("FAIL mid_reset got we_n=%b ce_n=%b oe=%b dq=%h addr=%h required 1 1 0 0 0",
        sram_we_n, sram_ce_n, sram_dq_oe, sram_dq_o, sram_addr);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    read_reg(2'd1, s);
    vectors++;
    if (s !== 32'h0) begin miscompares++; $display("FAIL mid_status got %h required 0", s); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
